// File: rtl/cpx_accumulate.sv
// Integrate-and-dump for complex samples: sums sum_len accepted I/Q pairs per block
// and presents each block sum through a one-deep valid/ready output slot.
module cpx_accumulate #(
  parameter int i_bits     = 24,
  parameter int q_bits     = 24,
  parameter int sum_len    = 16,
  parameter int cnt_bits   = 4,
  parameter int out_i_bits = 28,
  parameter int out_q_bits = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  m_axis_tvalid,
  input  logic [i_bits-1:0]     i,
  input  logic [q_bits-1:0]     q,
  output logic                  s_axis_tready,
  input  logic                  m_axis_tready,
  output logic                  s_axis_tvalid,
  output logic [out_i_bits-1:0] sum_i,
  output logic [out_q_bits-1:0] sum_q,
  output logic [cnt_bits-1:0]   count
);

  localparam logic [cnt_bits-1:0] last_cnt = cnt_bits'(sum_len - 1);

  logic [out_i_bits-1:0] acc_i;
  logic [out_q_bits-1:0] acc_q;
  logic [out_i_bits-1:0] ext_i;
  logic [out_q_bits-1:0] ext_q;
  logic [out_i_bits-1:0] next_i;
  logic [out_q_bits-1:0] next_q;
  logic                  last;
  logic                  accept;

  assign ext_i  = {{(out_i_bits - i_bits){i[i_bits-1]}}, i};
  assign ext_q  = {{(out_q_bits - q_bits){q[q_bits-1]}}, q};
  assign next_i = acc_i + ext_i;
  assign next_q = acc_q + ext_q;
  assign last   = (count == last_cnt);

  // The final sample of a block may only land when the output slot is empty or draining.
  assign s_axis_tready = ~clear & ~(last & s_axis_tvalid & ~m_axis_tready);
  assign accept        = m_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i         <= '0;
      acc_q         <= '0;
      count         <= '0;
      sum_i         <= '0;
      sum_q         <= '0;
      s_axis_tvalid <= 1'b0;
    end else begin
      if (s_axis_tvalid & m_axis_tready)
        s_axis_tvalid <= 1'b0;

      if (clear) begin
        acc_i <= '0;
        acc_q <= '0;
        count <= '0;
      end else if (accept) begin
        if (last) begin
          // A same-cycle drain is overridden here, giving bubble-free back-to-back blocks.
          sum_i         <= next_i;
          sum_q         <= next_q;
          s_axis_tvalid <= 1'b1;
          acc_i         <= '0;
          acc_q         <= '0;
          count         <= '0;
        end else begin
          acc_i <= next_i;
          acc_q <= next_q;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cpx_accumulate.md
Name: cpx_accumulate

Overview:
- Streaming consumer for complex products (I/Q pairs), e.g. cpx_multiply results.
- Sums sum_len consecutive accepted samples per block, then emits one registered complex sum with a valid/ready handshake.
- Forms the integrate-and-dump stage of the CAF correlation path.
- Accumulation of the next block continues while a finished result waits for downstream.

Parameters:
- i_bits, 24, width of signed input I sample
- q_bits, 24, width of signed input Q sample
- sum_len, 16, samples per block; must be >= 2
- cnt_bits, 4, counter width; equals clog2(sum_len)
- out_i_bits, 28, signed output I width; equals i_bits + cnt_bits
- out_q_bits, 28, signed output Q width; equals q_bits + cnt_bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous abort of the partial block
- m_axis_tvalid  input  1  upstream sample valid
- i  input  i_bits  signed input I
- q  input  q_bits  signed input Q
- s_axis_tready  output  1  block can accept a sample this cycle
- m_axis_tready  input  1  downstream ready for the result
- s_axis_tvalid  output  1  result valid
- sum_i  output  out_i_bits  signed block sum, I
- sum_q  output  out_q_bits  signed block sum, Q
- count  output  cnt_bits  samples accepted in the current partial block

Behaviour:
- Reset (rst high at an edge): acc_i, acc_q, count, sum_i, sum_q and s_axis_tvalid are all 0. rst overrides every other input.
- Accept: sample accepted at an edge when m_axis_tvalid & s_axis_tready.
- Ready is combinational from registered state plus clear and m_axis_tready:
  - s_axis_tready = ~clear & ~(count == sum_len-1 & s_axis_tvalid & ~m_axis_tready).
  - It stalls only on the final sample of a block, and only when the output slot is occupied and not draining.
- Arithmetic: i and q are sign-extended to out widths before adding. There is no overflow by construction; no saturation and no rounding.
- Non-final accept (count < sum_len-1):
  - acc_i <= acc_i + i; acc_q <= acc_q + q; count <= count + 1.
- Final accept (count == sum_len-1):
  - sum_i <= acc_i + i; sum_q <= acc_q + q.
  - s_axis_tvalid <= 1; acc_i, acc_q, count <= 0.
  - Latency: result is valid on the edge after the last sample is accepted.
- Output handshake:
  - While s_axis_tvalid & ~m_axis_tready, sum_i and sum_q hold stable.
  - When s_axis_tvalid & m_axis_tready and no final accept occurs that cycle, s_axis_tvalid <= 0. sum_i and sum_q keep their last value.
  - Final accept in the same cycle as a downstream handshake: the new sum loads and s_axis_tvalid stays 1, allowing back-to-back blocks with no bubble.
- clear:
  - acc_i, acc_q, count <= 0. The sample on that cycle is not accepted, because ready is forced low.
  - A pending result (s_axis_tvalid, sum_i, sum_q) is unaffected and still drains normally.
- No accept and no clear: accumulators and count hold.
- Wrap: count never reaches sum_len; it returns to 0 on the final accept.
- States are implicit:
  - ACCUM: count < sum_len-1.
  - LAST: count == sum_len-1; stalls if the output slot is busy.
  - The output slot is full or empty according to s_axis_tvalid.

Test Plan:
- Basic block (sum_len=4, i_bits=q_bits=8): feed (1,-1), (2,-2), (3,-3), (4,-4) every cycle with m_axis_tready=1 -> one cycle after the 4th accept, s_axis_tvalid=1 with sum_i=10, sum_q=-10; count returns to 0.
- Extremes: 4 samples of (-128, 127) -> sum_i=-512, sum_q=508 with no wrap; signed 10-bit output correct.
- Backpressure: m_axis_tready=0 after block 1 (sum 10) while block 2 ((1,1)x4) streams -> 3 samples accepted, s_axis_tready=0 at count=3, sum_i held at 10. Raising m_axis_tready -> same-cycle final accept; next cycle sum_i=4, s_axis_tvalid stays 1.
- Gapped input: m_axis_tvalid toggling every other cycle -> count advances only on accepts; final sum is identical to the gapless case.
- clear: clear at count=2 with samples pending -> count=0 and the sample that cycle is dropped; the next 4 samples of (5,5) give sum 20. A previously pending result is still delivered unchanged.
- Reset mid-block: rst at count=3 with s_axis_tvalid=1 -> next cycle s_axis_tvalid=0, count=0, sum_i=sum_q=0, and no stale result appears.
